mw_controller_param: RTL and testbench

- Parametrised successor to the microwave controller.
- Takes one-hot keypad entry of an MM:SS cook time and a selectable power level (1-10).
- Counts down on a parametrised seconds prescaler and duty-cycles the magnetron by power level over a repeating window.
- Adds pause/resume, end-of-cook beep and door interlock; drives four 7-segment digits.

---
 rtl/mw_controller_param_if.sv | 27 ++
 rtl/mw_controller_param.sv | 187 ++++++++++++++++++
 tb/tb_mw_controller_param.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mw_controller_param_if.sv
// Front-panel bundle for the microwave controller: keypad, buttons and door in, magnetron/beeper/status and four 7-segment digits out.
interface mw_controller_param_if;
    logic [9:0] keypad;
    logic       startn;
    logic       stopn;
    logic       pwr_keyn;
    logic       door_closed;
    logic       mag_on;
    logic       beep;
    logic       cooking;
    logic [6:0] sec_ones_segs;
    logic [6:0] sec_tens_segs;
    logic [6:0] min_ones_segs;
    logic [6:0] min_tens_segs;

    modport master (
        output keypad, startn, stopn, pwr_keyn, door_closed,
        input  mag_on, beep, cooking,
        input  sec_ones_segs, sec_tens_segs, min_ones_segs, min_tens_segs
    );

    modport slave (
        input  keypad, startn, stopn, pwr_keyn, door_closed,
        output mag_on, beep, cooking,
        output sec_ones_segs, sec_tens_segs, min_ones_segs, min_tens_segs
    );
endinterface

// File: rtl/mw_controller_param.sv
// Microwave controller: MM:SS keypad entry, power-level duty cycling, pause/resume, end beep, door interlock.
// State reacts one clk after an input edge; mag_on is combinational on door_closed. No backpressure: inputs sampled every clk.
module mw_controller_param #(
    parameter int TICKS_PER_SEC = 100,
    parameter int PWR_WINDOW    = 10,
    parameter int BEEP_SEC      = 3
) (
    input  logic                   clk,
    input  logic                   clearn,
    mw_controller_param_if.slave   io
);

    localparam int TW  = $clog2(TICKS_PER_SEC);
    localparam int PHW = (PWR_WINDOW > 1) ? $clog2(PWR_WINDOW) : 1;
    localparam int PWW = ($clog2(PWR_WINDOW + 1) > 4) ? $clog2(PWR_WINDOW + 1) : 4;
    localparam int BW  = (BEEP_SEC > 1) ? $clog2(BEEP_SEC) : 1;
    localparam logic [6:0] SEG_P = 7'b1110011;

    typedef enum logic [2:0] {S_IDLE, S_PWR, S_COOK, S_PAUSED, S_DONE} state_t;

    state_t         state;
    logic [3:0]     mt, mo, st, so;
    logic [PWW-1:0] power;
    logic [TW-1:0]  tick;
    logic [PHW-1:0] phase;
    logic [BW-1:0]  beep_cnt;
    logic           beep_q;
    logic [9:0]     kp_prev;
    logic           start_prev, stop_prev, pwr_prev;

    logic           key_evt, start_evt, stop_evt, pwr_evt, sec_wrap, time_nz, d_zero;
    logic [3:0]     key_val, d_mt, d_mo, d_st, d_so;
    logic [PWW-1:0] key_pwr;
    logic [PHW-1:0] phase_nxt;
    logic [3:0]     pw_h, pw_t, pw_o;

    assign key_evt   = (kp_prev == 10'd0) && $onehot(io.keypad);
    assign start_evt = start_prev & ~io.startn;
    assign stop_evt  = stop_prev & ~io.stopn;
    assign pwr_evt   = pwr_prev & ~io.pwr_keyn;
    assign sec_wrap  = (tick == TW'(TICKS_PER_SEC - 1));
    assign time_nz   = |{mt, mo, st, so};
    assign phase_nxt = (phase == PHW'(PWR_WINDOW - 1)) ? '0 : phase + PHW'(1);

    always_comb begin
        key_val = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (io.keypad[i]) key_val = 4'(i);
        end
        if (key_val == 4'd0 || 32'(key_val) > PWR_WINDOW) key_pwr = PWW'(PWR_WINDOW);
        else                                               key_pwr = PWW'(key_val);
    end

    // Minutes-ones borrow sets seconds-tens to 5, so entered values like 01:75 count 75, 74, ...
    always_comb begin
        d_so = so - 4'd1;
        d_st = st;
        d_mo = mo;
        d_mt = mt;
        if (so == 4'd0) begin
            d_so = 4'd9;
            d_st = st - 4'd1;
            if (st == 4'd0) begin
                d_st = 4'd5;
                d_mo = mo - 4'd1;
                if (mo == 4'd0) begin
                    d_mo = 4'd9;
                    d_mt = mt - 4'd1;
                end
            end
        end
        d_zero = ({d_mt, d_mo, d_st, d_so} == 16'd0);
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state      <= S_IDLE;
            {mt, mo, st, so} <= 16'd0;
            power      <= PWW'(PWR_WINDOW);
            tick       <= '0;
            phase      <= '0;
            beep_cnt   <= '0;
            beep_q     <= 1'b0;
            kp_prev    <= 10'd0;
            start_prev <= 1'b1;
            stop_prev  <= 1'b1;
            pwr_prev   <= 1'b1;
        end else begin
            kp_prev    <= io.keypad;
            start_prev <= io.startn;
            stop_prev  <= io.stopn;
            pwr_prev   <= io.pwr_keyn;
            case (state)
                S_IDLE: begin
                    if (stop_evt) begin
                        {mt, mo, st, so} <= 16'd0;
                    end else if (pwr_evt) begin
                        state <= S_PWR;
                    end else if (start_evt && io.door_closed && time_nz) begin
                        state <= S_COOK;
                        tick  <= '0;
                        phase <= '0;
                    end else if (key_evt) begin
                        {mt, mo, st, so} <= {mo, st, so, key_val};
                    end
                end
                S_PWR: begin
                    if (stop_evt) begin
                        state <= S_IDLE;
                    end else if (key_evt) begin
                        power <= key_pwr;
                        state <= S_IDLE;
                    end
                end
                S_COOK: begin
                    // Tick keeps running on the pausing edge; a coincident second is still counted.
                    tick <= sec_wrap ? '0 : tick + TW'(1);
                    if (sec_wrap) begin
                        {mt, mo, st, so} <= {d_mt, d_mo, d_st, d_so};
                        phase <= phase_nxt;
                    end
                    if (sec_wrap && d_zero) begin
                        state    <= S_DONE;
                        beep_q   <= 1'b1;
                        beep_cnt <= '0;
                    end else if (stop_evt || !io.door_closed) begin
                        state <= S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    if (stop_evt) begin
                        state <= S_IDLE;
                        {mt, mo, st, so} <= 16'd0;
                    end else if (start_evt && io.door_closed) begin
                        state <= S_COOK;
                    end
                end
                S_DONE: begin
                    tick <= sec_wrap ? '0 : tick + TW'(1);
                    if (key_evt || stop_evt || start_evt) begin
                        state  <= S_IDLE;
                        beep_q <= 1'b0;
                    end else if (sec_wrap) begin
                        if (beep_cnt == BW'(BEEP_SEC - 1)) begin
                            state  <= S_IDLE;
                            beep_q <= 1'b0;
                        end else begin
                            beep_cnt <= beep_cnt + BW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'b0111111;
            4'd1: seg7 = 7'b0000110;
            4'd2: seg7 = 7'b1011011;
            4'd3: seg7 = 7'b1001111;
            4'd4: seg7 = 7'b1100110;
            4'd5: seg7 = 7'b1101101;
            4'd6: seg7 = 7'b1111101;
            4'd7: seg7 = 7'b0000111;
            4'd8: seg7 = 7'b1111111;
            4'd9: seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        pw_o = 4'(32'(power) % 10);
        pw_t = 4'((32'(power) / 10) % 10);
        pw_h = 4'((32'(power) / 100) % 10);
    end

    assign io.mag_on        = (state == S_COOK) && io.door_closed && (32'(phase) < 32'(power));
    assign io.beep          = beep_q;
    assign io.cooking       = (state == S_COOK);
    assign io.min_tens_segs = (state == S_PWR) ? SEG_P      : seg7(mt);
    assign io.min_ones_segs = (state == S_PWR) ? seg7(pw_h) : seg7(mo);
    assign io.sec_tens_segs = (state == S_PWR) ? seg7(pw_t) : seg7(st);
    assign io.sec_ones_segs = (state == S_PWR) ? seg7(pw_o) : seg7(so);

endmodule

// File: tb/tb_mw_controller_param.sv
// Directed bench for mw_controller_param (4 ticks/s, 10 s window, 3 s beep); expectations queued, checked by a negedge monitor.
module tb_mw_controller_param;

    logic clk = 1'b0;
    logic clearn;
    always #5 clk = ~clk;

    mw_controller_param_if ifc();

    mw_controller_param #(
        .TICKS_PER_SEC(4),
        .PWR_WINDOW   (10),
        .BEEP_SEC     (3)
    ) dut (
        .clk   (clk),
        .clearn(clearn),
        .io    (ifc)
    );

    typedef struct {
        int          cyc;
        string       name;
        logic [30:0] vec;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc    = 0;
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [30:0] act;

    assign act = {ifc.mag_on, ifc.beep, ifc.cooking, ifc.min_tens_segs,
                  ifc.min_ones_segs, ifc.sec_tens_segs, ifc.sec_ones_segs};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            n_chk++;
            if (mon_e.cyc != cyc)
                $display("FAIL %s: not sampled in its cycle (due %0d, now %0d)", mon_e.name, mon_e.cyc, cyc);
            else if (act !== mon_e.vec)
                $display("FAIL %s: got %h expected %h {mag,beep,cook,segs}", mon_e.name, act, mon_e.vec);
            else
                n_pass++;
        end
    end

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'h3F;  1: seg = 7'h06;  2: seg = 7'h5B;  3: seg = 7'h4F;  4: seg = 7'h66;
            5: seg = 7'h6D;  6: seg = 7'h7D;  7: seg = 7'h07;  8: seg = 7'h7F;  9: seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    endfunction

    task automatic expect_raw(input string name, input logic mag, input logic bp, input logic ck,
                              input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.vec  = {mag, bp, ck, s3, s2, s1, s0};
        sb.push_back(e);
    endtask

    // t is the displayed MMSS as a decimal number, e.g. 71 for 00:71
    task automatic expect_t(input string name, input logic mag, input logic bp, input logic ck, input int t);
        expect_raw(name, mag, bp, ck, seg((t / 1000) % 10), seg((t / 100) % 10), seg((t / 10) % 10), seg(t % 10));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        ifc.startn = 1'b0; step(1); ifc.startn = 1'b1; step(1);
    endtask

    task automatic press_stop();
        ifc.stopn = 1'b0; step(1); ifc.stopn = 1'b1; step(1);
    endtask

    task automatic press_pwr();
        ifc.pwr_keyn = 1'b0; step(1); ifc.pwr_keyn = 1'b1; step(1);
    endtask

    task automatic key(input int k);
        ifc.keypad = 10'(1 << k); step(1); ifc.keypad = 10'd0; step(1);
    endtask

    initial begin
        clearn          = 1'b0;
        ifc.keypad      = 10'd0;
        ifc.startn      = 1'b1;
        ifc.stopn       = 1'b1;
        ifc.pwr_keyn    = 1'b1;
        ifc.door_closed = 1'b1;
        step(2);
        expect_t("reset", 0, 0, 0, 0);
        clearn = 1'b1;
        step(1);

        // Countdown 00:71 -> 00:59, then stop twice
        key(7); key(1);
        expect_t("entry_71", 0, 0, 0, 71);
        press_start();
        expect_t("start_mag", 1, 0, 1, 71);
        step(2);  expect_t("pre_dec", 1, 0, 1, 71);
        step(1);  expect_t("dec_70", 1, 0, 1, 70);
        step(43); expect_t("pre_59", 1, 0, 1, 60);
        step(1);  expect_t("borrow_59", 1, 0, 1, 59);
        press_stop(); expect_t("stop_pause", 0, 0, 0, 59);
        press_stop(); expect_t("stop_clear", 0, 0, 0, 0);

        // 00:03 at power 10 -> DONE, beep 12 cycles
        key(3);
        press_start(); expect_t("cook_03", 1, 0, 1, 3);
        step(10); expect_t("pre_done", 1, 0, 1, 1);
        step(1);  expect_t("done", 0, 1, 0, 0);
        step(11); expect_t("beep_last", 0, 1, 0, 0);
        step(1);  expect_t("beep_end", 0, 0, 0, 0);

        // Power 3 duty cycle
        press_pwr();
        expect_raw("pwr_entry", 0, 0, 0, 7'b1110011, seg(0), seg(1), seg(0));
        key(3);   expect_t("pwr_set", 0, 0, 0, 0);
        press_pwr();
        expect_raw("pwr_show3", 0, 0, 0, 7'b1110011, seg(0), seg(0), seg(3));
        press_stop(); expect_t("pwr_cancel", 0, 0, 0, 0);
        key(2); key(0);
        press_start(); expect_t("duty_s0", 1, 0, 1, 20);
        step(10); expect_t("duty_s2", 1, 0, 1, 18);
        step(1);  expect_t("duty_s3", 0, 0, 1, 17);
        step(27); expect_t("duty_s9", 0, 0, 1, 11);
        step(1);  expect_t("duty_s10", 1, 0, 1, 10);

        // Door open mid-cook, then resume from held tick
        step(1);
        ifc.door_closed = 1'b0;
        expect_t("door_drop", 0, 0, 1, 10);
        step(1); expect_t("door_pause", 0, 0, 0, 10);
        step(5); expect_t("pause_frozen", 0, 0, 0, 10);
        ifc.door_closed = 1'b1;
        press_start(); expect_t("resume", 1, 0, 1, 10);
        step(1); expect_t("resume_tick", 1, 0, 1, 9);
        press_stop(); expect_t("pause2", 0, 0, 0, 9);
        press_stop(); expect_t("clear2", 0, 0, 0, 0);

        // Start refused: zero time, door open
        press_start(); expect_t("start_zero", 0, 0, 0, 0);
        key(5);
        ifc.door_closed = 1'b0;
        press_start(); expect_t("start_door", 0, 0, 0, 5);
        ifc.door_closed = 1'b1;

        // Multi-bit and held keypad
        ifc.keypad = 10'b0000000011; step(1); ifc.keypad = 10'd0; step(1);
        expect_t("multibit", 0, 0, 0, 5);
        ifc.keypad = 10'(1 << 4); step(3); ifc.keypad = 10'd0; step(1);
        expect_t("held_key", 0, 0, 0, 54);

        // Async clear mid-cook restores power 10
        press_start(); expect_t("cook_54", 1, 0, 1, 54);
        step(2);
        clearn = 1'b0;
        expect_t("async_clear", 0, 0, 0, 0);
        step(1); clearn = 1'b1; step(1);
        press_pwr();
        expect_raw("pwr_after_clear", 0, 0, 0, 7'b1110011, seg(0), seg(1), seg(0));
        press_stop();

        // Key in DONE returns to IDLE without entering a digit
        key(1);
        press_start(); step(2); expect_t("pre_done2", 1, 0, 1, 1);
        step(1); expect_t("done2", 0, 1, 0, 0);
        key(9);  expect_t("done_key_exit", 0, 0, 0, 0);

        step(3);
        if (sb.size() != 0) begin
            $display("FAIL leftover: %0d expectations never sampled, required 0", sb.size());
            n_chk += sb.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
